// File: rtl/logic_pkg.sv
// Shared definitions for the logical-unit execute stage.
//   op_e        : 3-bit opcode encoding carried from decode.
//   WIDTH_DEF   : default operand/result width.
//   TAG_W_DEF   : default destination tag width.
package logic_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int TAG_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_NOT_B = 3'd7
  } op_e;

endpackage

// File: rtl/logic_func_32.sv
// Combinational logic function unit with result flags.
//   op     : opcode (logic_pkg::op_e encoding)
//   a, b   : operands
//   result : selected logical function of a and b
//   zero   : result == 0
//   neg    : result MSB
//   parity : XOR-reduction of result (1 = odd number of ones)
module logic_func_32
  import logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             parity
);

  // NOTE: the default assignment before the case keeps this block free of
  // inferred latches even if an arm is ever removed.
  always_comb begin
    result = '0;
    unique case (op_e'(op))
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_XNOR:  result = ~(a ^ b);
      OP_NOT_A: result = ~a;
      OP_NOT_B: result = ~b;
      default:  result = '0;
    endcase
  end

  assign zero   = (result == '0);
  assign neg    = result[WIDTH-1];
  assign parity = ^result;

endmodule

// File: rtl/logic_exec_stage.sv
// Two-stage pipelined execute stage for the logical unit.
//   in_valid/in_ready      : upstream handshake; in_op/in_a/in_b/in_tag captured
//                            into stage 1 on transfer.
//   out_valid/out_ready    : downstream handshake; out_result/out_tag/flags
//                            come from the stage-2 result register.
//   out_zero/neg/parity    : flags of out_result, registered with it.
//   op_count               : wrapping count of completed output transfers.
// Stage 1 holds operands, stage 2 holds the computed result. Both stages
// advance together when the output is free, giving one op per cycle.
module logic_exec_stage
  import logic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;

  logic [WIDTH-1:0] f_result;
  logic             f_zero;
  logic             f_neg;
  logic             f_parity;

  logic s2_adv;
  logic s1_load;
  logic s2_load;
  logic out_xfer;

  // Stage 2 can take new data when empty or when its content leaves this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  // Stage 1 can take new data when empty or when it moves into stage 2.
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_adv;
  assign out_xfer = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // NOTE: every register here, data included, is cleared by reset so that no
  // stale operand or result is ever visible after rst_n is released.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers sample the pre-edge values of their neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_tag   <= in_tag;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  logic_func_32 #(.WIDTH(WIDTH)) u_func (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (f_result),
    .zero   (f_zero),
    .neg    (f_neg),
    .parity (f_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid   <= 1'b1;
        out_result <= f_result;
        out_tag    <= s1_tag;
        out_zero   <= f_zero;
        out_neg    <= f_neg;
        out_parity <= f_parity;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_xfer) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule
